regfile_blockxfer_seq: RTL and testbench
========================================

Name: regfile_blockxfer_seq

Overview:
Sequencer for ARM LDM/STM block transfers. It walks a 16-bit register list and drives the register-file read/write ports and a single-beat memory request interface, one register per beat. It sits between the decode/execute control and the `registers` file plus the memory port, and owns the register-file ports while busy. It also computes the transfer addresses and the optional base writeback.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, data width; matches register-file data width
REG_W, 5, register-file index width; matches the register-file read/write index ports

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a transfer; sampled only in IDLE
is_load  in  1  1 = LDM (memory to reg), 0 = STM (reg to memory)
mode  in  2  00 IA, 01 IB, 10 DA, 11 DB
writeback  in  1  write the final base value to base_reg
base_reg  in  4  base register index
base_addr  in  ADDR_W  base register value, captured at start
reg_list  in  16  bit i set = transfer Ri
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse at completion
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word address of the current beat
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  beat complete
read_reg_num  out  REG_W  register-file read index (STM)
read_data  in  DATA_W  register-file read data; combinational from read_reg_num
write_reg  out  REG_W  register-file write index
write_data  out  DATA_W  register-file write data
regwrite  out  1  register-file write enable

Behaviour:
- Reset values: all outputs are 0; state is IDLE; internal list, address and count registers are cleared.
- Reset mid-operation returns to IDLE immediately. No regwrite or mem_req is issued in the reset cycle or after it, and any partial transfer is abandoned.
- FSM states: IDLE, CALC, XFER, LWR, WB, DONE.
- IDLE:
  - On start=1, capture reg_list, base_addr, mode, is_load, writeback and base_reg, then go to CALC.
  - start is ignored while not in IDLE.
- CALC (1 cycle):
  - n = popcount(list).
  - Start address: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n.
  - Final base: up modes = base+4n; down modes = base-4n. All arithmetic is mod 2^ADDR_W, so wrap-around is allowed silently.
  - If n = 0, go to DONE: no beats, no writeback.
- XFER:
  - The current register is the lowest set bit of the remaining list. Lowest register always goes to the lowest address.
  - Drive mem_req=1, mem_we=~is_load, mem_addr = current address, read_reg_num = {0, idx}, mem_wdata = read_data.
  - All of these are held stable until mem_ack=1. mem_ack may be high in the first req cycle, so the minimum is 1 cycle per beat.
  - On ack:
    - Clear that bit and add 4 to the address.
    - Load: capture mem_rdata and idx, then go to LWR.
    - Store with bits remaining: stay in XFER.
    - Otherwise: go to WB.
  - mem_req drops for at least 1 cycle between load beats because of LWR; store beats may be back-to-back.
- LWR (1 cycle):
  - regwrite=1 with the captured idx and data.
  - Then XFER if bits remain, else WB.
- WB (1 cycle):
  - If writeback=1: regwrite=1, write_reg=base_reg, write_data = final base.
  - Exception: for a load with base_reg in the original list, writeback is suppressed and the loaded value wins.
  - Then go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. busy=0 in IDLE.
- Latency: start sampled at edge k gives mem_req high from cycle k+2.
  - Store total = 2 + n·(ack wait) + 2 cycles.
  - Load adds 1 cycle per beat.
- regwrite is never asserted in the same cycle as mem_req.

Optional Feature:
REGSEQ_BEAT_CNT_EN:
- When defined, adds output beat_count[31:0]. It increments on every acked beat, clears on reset, and wraps at 2^32.
- When undefined, the port and its counter are absent; everything else is unchanged.

Decomposition:
- Package regseq_pkg holds:
  - state enum: IDLE, CALC, XFER, LWR, WB, DONE
  - mode constants: IA, IB, DA, DB
  - WORD_BYTES = 4
  - REG_LIST_W = 16
- One natural combinational sub-module: lowest_set_bit16. Inputs: 16-bit vector. Outputs: 4-bit index, any-set flag, 5-bit popcount. It is used in CALC and XFER.

Test Plan:
- Reset then STM IA, reg_list=16'h000E (R1–R3), base 0x1000, R1..R3 = 0x11/0x22/0x33, ack same cycle -> writes 0x1000=0x11, 0x1004=0x22, 0x1008=0x33; mem_req first seen 2 cycles after start; done pulse; no regwrite.
- LDM DB, list=16'h8001, base 0x2000, writeback=1, base_reg=13, rdata 0xAA then 0xBB -> reads 0x1FF8 into R0=0xAA and 0x1FFC into R15=0xBB; then R13=0x1FF8.
- LDM IA, base_reg=2, list includes R2, writeback=1 -> R2 holds the loaded value; no writeback regwrite.
- Empty list with writeback=1 -> no mem_req, no regwrite; done 2 cycles after start.
- STM IB with mem_ack delayed 3 cycles per beat, plus a start pulse while busy -> address/we/wdata stable across the wait; the second start is ignored.
- Reset asserted mid-LDM after the first ack -> outputs 0 next cycle, no LWR regwrite; a subsequent start runs normally.

Source files
------------

// File: rtl/regseq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package regseq_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned REG_LIST_W = 16;
    localparam int unsigned REG_IDX_W  = 4;
    localparam int unsigned REG_CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        XFER = 3'd2,
        LWR  = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        IA = 2'b00,
        IB = 2'b01,
        DA = 2'b10,
        DB = 2'b11
    } mode_e;

    // Increment-after/increment-before modes move the base upwards.
    function automatic logic mode_is_up(input mode_e m);
        return (m == IA) || (m == IB);
    endfunction

endpackage

// File: rtl/lowest_set_bit16.sv
// Lowest-set-bit index, any-set flag and population count of a 16-bit list.
module lowest_set_bit16
    import regseq_pkg::*;
(
    input  logic [REG_LIST_W-1:0] vec_i,
    output logic [REG_IDX_W-1:0]  idx_o,
    output logic                  any_o,
    output logic [REG_CNT_W-1:0]  cnt_o
);

    // Scan from the top so the last hit is the lowest set bit.
    always_comb begin
        idx_o = '0;
        cnt_o = '0;
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = REG_IDX_W'(i);
            end
            cnt_o = cnt_o + REG_CNT_W'(vec_i[i]);
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/regfile_blockxfer_seq.sv
// LDM/STM block-transfer sequencer: walks a register list one beat at a time,
// driving the register-file ports and a single-beat memory request port.
// Optional build macro: REGSEQ_BEAT_CNT_EN adds a 32-bit acked-beat counter.
module regfile_blockxfer_seq
    import regseq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [1:0]        mode,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [REG_W-1:0]  read_reg_num,
    input  logic [DATA_W-1:0] read_data,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              regwrite
`ifdef REGSEQ_BEAT_CNT_EN
    ,
    output logic [31:0]       beat_count
`endif
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_e                  state_q;
    logic [REG_LIST_W-1:0]   list_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       final_q;
    mode_e                   mode_q;
    logic                    load_q;
    logic                    wb_q;
    logic                    base_in_list_q;
    logic [3:0]              base_reg_q;

    logic                    busy_q;
    logic                    done_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [REG_W-1:0]        read_reg_num_q;
    logic [REG_W-1:0]        write_reg_q;
    logic [DATA_W-1:0]       write_data_q;
    logic                    regwrite_q;

    logic [REG_LIST_W-1:0]   lsb_in_c;
    logic [REG_IDX_W-1:0]    lsb_idx_c;
    logic                    lsb_any_c;
    logic [REG_CNT_W-1:0]    lsb_cnt_c;
    logic [ADDR_W-1:0]       four_n_c;
    logic [ADDR_W-1:0]       start_addr_c;
    logic [ADDR_W-1:0]       final_addr_c;
    logic                    wb_en_c;

    // In XFER look past the in-flight register so the next beat is ready at the ack edge.
    always_comb begin
        lsb_in_c = list_q;
        if (state_q == XFER) begin
            lsb_in_c = list_q & (list_q - REG_LIST_W'(1));
        end
    end

    lowest_set_bit16 u_lsb (
        .vec_i (lsb_in_c),
        .idx_o (lsb_idx_c),
        .any_o (lsb_any_c),
        .cnt_o (lsb_cnt_c)
    );

    // Start and final base addresses from the captured base and list size.
    always_comb begin
        four_n_c = ADDR_W'(lsb_cnt_c) * STEP;
        unique case (mode_q)
            IA:      start_addr_c = base_q;
            IB:      start_addr_c = base_q + STEP;
            DA:      start_addr_c = base_q - four_n_c + STEP;
            default: start_addr_c = base_q - four_n_c;
        endcase
        final_addr_c = mode_is_up(mode_q) ? (base_q + four_n_c) : (base_q - four_n_c);
        // A loaded base register keeps its loaded value instead of the writeback.
        wb_en_c = wb_q & ~(load_q & base_in_list_q);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            list_q         <= '0;
            base_q         <= '0;
            addr_q         <= '0;
            final_q        <= '0;
            mode_q         <= IA;
            load_q         <= 1'b0;
            wb_q           <= 1'b0;
            base_in_list_q <= 1'b0;
            base_reg_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            read_reg_num_q <= '0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            regwrite_q     <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        list_q         <= reg_list;
                        base_q         <= base_addr;
                        mode_q         <= mode_e'(mode);
                        load_q         <= is_load;
                        wb_q           <= writeback;
                        base_reg_q     <= base_reg;
                        base_in_list_q <= reg_list[base_reg];
                        busy_q         <= 1'b1;
                        state_q        <= CALC;
                    end
                end
                CALC: begin
                    final_q <= final_addr_c;
                    if (lsb_any_c) begin
                        addr_q         <= start_addr_c;
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= ~load_q;
                        mem_addr_q     <= start_addr_c;
                        read_reg_num_q <= REG_W'(lsb_idx_c);
                        state_q        <= XFER;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        list_q <= lsb_in_c;
                        addr_q <= addr_q + STEP;
                        if (load_q) begin
                            mem_req_q      <= 1'b0;
                            mem_we_q       <= 1'b0;
                            mem_addr_q     <= '0;
                            read_reg_num_q <= '0;
                            regwrite_q     <= 1'b1;
                            write_reg_q    <= read_reg_num_q;
                            write_data_q   <= mem_rdata;
                            state_q        <= LWR;
                        end else if (lsb_any_c) begin
                            mem_addr_q     <= addr_q + STEP;
                            read_reg_num_q <= REG_W'(lsb_idx_c);
                        end else begin
                            mem_req_q      <= 1'b0;
                            mem_we_q       <= 1'b0;
                            mem_addr_q     <= '0;
                            read_reg_num_q <= '0;
                            regwrite_q     <= wb_en_c;
                            if (wb_en_c) begin
                                write_reg_q  <= REG_W'(base_reg_q);
                                write_data_q <= DATA_W'(final_q);
                            end
                            state_q <= WB;
                        end
                    end
                end
                LWR: begin
                    if (lsb_any_c) begin
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= ~load_q;
                        mem_addr_q     <= addr_q;
                        read_reg_num_q <= REG_W'(lsb_idx_c);
                        state_q        <= XFER;
                    end else begin
                        regwrite_q <= wb_en_c;
                        if (wb_en_c) begin
                            write_reg_q  <= REG_W'(base_reg_q);
                            write_data_q <= DATA_W'(final_q);
                        end
                        state_q <= WB;
                    end
                end
                WB: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

`ifdef REGSEQ_BEAT_CNT_EN
    logic [31:0] beat_cnt_q;

    // Free-running count of acked beats, wrapping naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if ((state_q == XFER) && mem_ack) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign beat_count = beat_cnt_q;
`endif

    // Requests and writes are squashed in the reset cycle itself; store data
    // passes straight through from the combinational register-file read port.
    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_req      = mem_req_q & ~reset;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = (mem_req_q && mem_we_q) ? read_data : '0;
    assign read_reg_num = read_reg_num_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign regwrite     = regwrite_q & ~reset;

endmodule

// File: tb/tb_regfile_blockxfer_seq.sv
// Directed bench for regfile_blockxfer_seq with register-file and memory models.
module tb_regfile_blockxfer_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [1:0]  mode;
    logic        writeback;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic        busy, done, mem_req, mem_we, mem_ack, regwrite;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, read_data, write_data;
    logic [4:0]  read_reg_num, write_reg;
`ifdef REGSEQ_BEAT_CNT_EN
    logic [31:0] beat_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    regfile_blockxfer_seq dut (
`ifdef REGSEQ_BEAT_CNT_EN
        .beat_count   (beat_count),
`endif
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .is_load      (is_load),
        .mode         (mode),
        .writeback    (writeback),
        .base_reg     (base_reg),
        .base_addr    (base_addr),
        .reg_list     (reg_list),
        .busy         (busy),
        .done         (done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .read_reg_num (read_reg_num),
        .read_data    (read_data),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .regwrite     (regwrite)
    );

    // Register-file model with a preload port.
    logic [31:0] rf [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx;
    logic [31:0] pl_val;
    assign read_data = rf[read_reg_num];
    always @(posedge clock) begin
        if (pl_en) rf[pl_idx] <= pl_val;
        else if (regwrite) rf[write_reg] <= write_data;
    end

    // Memory responder and transaction logs.
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          ld_beat = 0;
    logic [31:0] rdata_tab [0:3];
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = rdata_tab[ld_beat[1:0]];

    logic        log_clr = 1'b0;
    int          log_n, req_n, rw_n, ovl_n, stab_n;
    logic [31:0] log_addr [0:15];
    logic [31:0] log_wdata [0:15];
    logic        log_we [0:15];
    logic [4:0]  rw_reg [0:15];
    logic [31:0] rw_data [0:15];
    logic        hold_v;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    always @(posedge clock) begin
        if (log_clr) begin
            log_n <= 0; req_n <= 0; rw_n <= 0; ovl_n <= 0; stab_n <= 0;
            ld_beat <= 0; wait_cnt <= 0; hold_v <= 1'b0;
        end else begin
            wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
            if (mem_req) req_n <= req_n + 1;
            if (mem_req && mem_ack) begin
                if (log_n < 16) begin
                    log_addr[log_n]  <= mem_addr;
                    log_wdata[log_n] <= mem_wdata;
                    log_we[log_n]    <= mem_we;
                end
                log_n <= log_n + 1;
                if (!mem_we) ld_beat <= ld_beat + 1;
            end
            if (regwrite) begin
                if (rw_n < 16) begin
                    rw_reg[rw_n]  <= write_reg;
                    rw_data[rw_n] <= write_data;
                end
                rw_n <= rw_n + 1;
            end
            if (regwrite && mem_req) ovl_n <= ovl_n + 1;
            if (hold_v && mem_req &&
                (mem_addr !== hold_addr || mem_wdata !== hold_wdata || mem_we !== hold_we))
                stab_n <= stab_n + 1;
            hold_v     <= mem_req && !mem_ack;
            hold_addr  <= mem_addr;
            hold_wdata <= mem_wdata;
            hold_we    <= mem_we;
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clock);
        pl_en = 1'b1; pl_idx = 5'(idx); pl_val = val;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic clear_logs();
        @(negedge clock); log_clr = 1'b1;
        @(negedge clock); log_clr = 1'b0;
    endtask

    // Pulse start for one edge; returns at the first negedge after it (cycle 1).
    task automatic launch(input logic ld, input logic [1:0] md, input logic wb,
                          input logic [3:0] breg, input logic [31:0] base, input logic [15:0] list);
        @(negedge clock);
        is_load = ld; mode = md; writeback = wb; base_reg = breg;
        base_addr = base; reg_list = list; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_load = 1'b0; mode = 2'b00; writeback = 1'b0;
        base_reg = 4'd0; base_addr = 32'd0; reg_list = 16'd0;
        clear_logs();
        repeat (2) @(negedge clock);
        tests++;
        if ({busy, done, mem_req, mem_we, regwrite} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_req, mem_we, regwrite});
        end
        tests++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || write_data !== 32'd0 ||
            read_reg_num !== 5'd0 || write_reg !== 5'd0) begin
            fails++; $display("FAIL reset_data: addr=%h wdata=%h wrdata=%h rr=%0d wr=%0d want all 0",
                              mem_addr, mem_wdata, write_data, read_reg_num, write_reg);
        end
        reset = 1'b0;
    endtask

    task automatic test_stm_ia();
        logic [31:0] ea [0:2];
        logic [31:0] ed [0:2];
        int cyc;
        ea[0] = 32'h1000; ea[1] = 32'h1004; ea[2] = 32'h1008;
        ed[0] = 32'h11;   ed[1] = 32'h22;   ed[2] = 32'h33;
        preload(1, 32'h11); preload(2, 32'h22); preload(3, 32'h33);
        ack_delay = 0;
        clear_logs();
        launch(1'b0, 2'b00, 1'b0, 4'd0, 32'h1000, 16'h000E);
        tests++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            fails++; $display("FAIL stm_ia_calc: busy=%b req=%b want busy=1 req=0", busy, mem_req);
        end
        @(negedge clock);
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'h11) begin
            fails++; $display("FAIL stm_ia_first_beat: req=%b we=%b addr=%h wdata=%h want 1 1 1000 11",
                              mem_req, mem_we, mem_addr, mem_wdata);
        end
        wait_done(2, cyc);
        tests++;
        if (cyc !== 6) begin
            fails++; $display("FAIL stm_ia_latency: done at cycle %0d want 6", cyc);
        end
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL stm_ia_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        tests++;
        if (log_n !== 3 || req_n !== 3 || rw_n !== 0 || ovl_n !== 0) begin
            fails++; $display("FAIL stm_ia_counts: beats=%0d req=%0d rw=%0d ovl=%0d want 3 3 0 0",
                              log_n, req_n, rw_n, ovl_n);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (log_addr[i] !== ea[i] || log_wdata[i] !== ed[i] || log_we[i] !== 1'b1) begin
                fails++; $display("FAIL stm_ia_beat%0d: addr=%h data=%h we=%b want %h %h 1",
                                  i, log_addr[i], log_wdata[i], log_we[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_ldm_db_wb();
        int cyc;
        ack_delay = 0;
        rdata_tab[0] = 32'hAA; rdata_tab[1] = 32'hBB;
        clear_logs();
        launch(1'b1, 2'b11, 1'b1, 4'd13, 32'h2000, 16'h8001);
        wait_done(1, cyc);
        tests++;
        if (cyc !== 7) begin
            fails++; $display("FAIL ldm_db_latency: done at cycle %0d want 7", cyc);
        end
        tests++;
        if (log_n !== 2 || log_addr[0] !== 32'h1FF8 || log_addr[1] !== 32'h1FFC ||
            log_we[0] !== 1'b0 || log_we[1] !== 1'b0) begin
            fails++; $display("FAIL ldm_db_addrs: n=%0d a0=%h a1=%h we=%b%b want 2 1ff8 1ffc 00",
                              log_n, log_addr[0], log_addr[1], log_we[0], log_we[1]);
        end
        tests++;
        if (rw_n !== 3 || rw_reg[0] !== 5'd0 || rw_data[0] !== 32'hAA ||
            rw_reg[1] !== 5'd15 || rw_data[1] !== 32'hBB ||
            rw_reg[2] !== 5'd13 || rw_data[2] !== 32'h1FF8) begin
            fails++; $display("FAIL ldm_db_writes: n=%0d r%0d=%h r%0d=%h r%0d=%h want R0=aa R15=bb R13=1ff8",
                              rw_n, rw_reg[0], rw_data[0], rw_reg[1], rw_data[1], rw_reg[2], rw_data[2]);
        end
        tests++;
        if (req_n !== 2 || ovl_n !== 0 || rf[13] !== 32'h1FF8) begin
            fails++; $display("FAIL ldm_db_misc: req=%0d ovl=%0d R13=%h want 2 0 1ff8", req_n, ovl_n, rf[13]);
        end
    endtask

    task automatic test_ldm_base_in_list();
        int cyc;
        ack_delay = 0;
        rdata_tab[0] = 32'h5555_0001; rdata_tab[1] = 32'h5555_0002;
        clear_logs();
        launch(1'b1, 2'b00, 1'b1, 4'd2, 32'h3000, 16'h0006);
        wait_done(1, cyc);
        tests++;
        if (cyc !== 7 || log_addr[0] !== 32'h3000 || log_addr[1] !== 32'h3004) begin
            fails++; $display("FAIL ldm_base_timing: cyc=%0d a0=%h a1=%h want 7 3000 3004",
                              cyc, log_addr[0], log_addr[1]);
        end
        tests++;
        if (rw_n !== 2 || rf[1] !== 32'h5555_0001 || rf[2] !== 32'h5555_0002) begin
            fails++; $display("FAIL ldm_base_suppress: rw=%0d R1=%h R2=%h want 2 55550001 55550002",
                              rw_n, rf[1], rf[2]);
        end
    endtask

    task automatic test_empty_list();
        int cyc;
        clear_logs();
        launch(1'b0, 2'b00, 1'b1, 4'd5, 32'h7000, 16'h0000);
        wait_done(1, cyc);
        tests++;
        if (cyc !== 2) begin
            fails++; $display("FAIL empty_latency: done at cycle %0d want 2", cyc);
        end
        tests++;
        if (req_n !== 0 || rw_n !== 0) begin
            fails++; $display("FAIL empty_activity: req=%0d rw=%0d want 0 0", req_n, rw_n);
        end
    endtask

    task automatic test_stm_ib_wait();
        int cyc;
        preload(4, 32'h44); preload(5, 32'h55);
        ack_delay = 3;
        clear_logs();
        launch(1'b0, 2'b01, 1'b0, 4'd0, 32'h4000, 16'h0030);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (cyc == 4) begin
                start = 1'b1; reg_list = 16'hFFFF; is_load = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tests++;
        if (cyc !== 11) begin
            fails++; $display("FAIL stm_ib_latency: done at cycle %0d want 11", cyc);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || log_n !== 2 || req_n !== 8) begin
            fails++; $display("FAIL stm_ib_ignore_start: busy=%b beats=%0d req=%0d want 0 2 8",
                              busy, log_n, req_n);
        end
        tests++;
        if (stab_n !== 0) begin
            fails++; $display("FAIL stm_ib_stable: %0d unstable cycles want 0", stab_n);
        end
        tests++;
        if (log_addr[0] !== 32'h4004 || log_wdata[0] !== 32'h44 ||
            log_addr[1] !== 32'h4008 || log_wdata[1] !== 32'h55) begin
            fails++; $display("FAIL stm_ib_beats: %h=%h %h=%h want 4004=44 4008=55",
                              log_addr[0], log_wdata[0], log_addr[1], log_wdata[1]);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_ldm();
        int cyc;
        ack_delay = 0;
        rdata_tab[0] = 32'hDEAD_0001; rdata_tab[1] = 32'hDEAD_0002;
        clear_logs();
        launch(1'b1, 2'b00, 1'b0, 4'd0, 32'h5000, 16'h0003);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++;
        if (regwrite !== 1'b0 || mem_req !== 1'b0) begin
            fails++; $display("FAIL midrst_same_cycle: regwrite=%b req=%b want 0 0", regwrite, mem_req);
        end
        @(negedge clock);
        tests++;
        if ({busy, done, mem_req, regwrite} !== 4'b0 || mem_addr !== 32'd0 || write_reg !== 5'd0) begin
            fails++; $display("FAIL midrst_outputs: ctrl=%b addr=%h wr=%0d want 0000 0 0",
                              {busy, done, mem_req, regwrite}, mem_addr, write_reg);
        end
        tests++;
        if (rw_n !== 0 || log_n !== 1) begin
            fails++; $display("FAIL midrst_abandon: rw=%0d beats=%0d want 0 1", rw_n, log_n);
        end
        reset = 1'b0;
        rdata_tab[0] = 32'hCAFE_0001;
        clear_logs();
        launch(1'b1, 2'b00, 1'b0, 4'd0, 32'h6000, 16'h0001);
        wait_done(1, cyc);
        tests++;
        if (cyc !== 5 || rw_n !== 1 || rf[0] !== 32'hCAFE_0001 || log_addr[0] !== 32'h6000) begin
            fails++; $display("FAIL midrst_rerun: cyc=%0d rw=%0d R0=%h a0=%h want 5 1 cafe0001 6000",
                              cyc, rw_n, rf[0], log_addr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_stm_ia();
        test_ldm_db_wb();
        test_ldm_base_in_list();
        test_empty_list();
        test_stm_ib_wait();
        test_reset_mid_ldm();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
